mul_seq: RTL and testbench
==========================

# mul_seq

Iterative multiply sequencer that borrows the shared 32-bit ALU to compute MUL/MLA results by shift-and-add. It sits beside the single-cycle datapath. While it runs, it owns the ALU operand and control inputs through a datapath mux, and it returns a 32-bit low-word product plus N/Z flags with a start/done handshake.

## Interface
- WIDTH, 32, operand/product width; must equal the ALU width.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only in IDLE or DONE.
- Accumulate  in  1  sampled with Start; 1 = MLA (product + Addend), 0 = MUL.
- Multiplicand  in  WIDTH  operand M, sampled with Start.
- Multiplier  in  WIDTH  operand Q, sampled with Start.
- Addend  in  WIDTH  accumulator seed, sampled with Start when Accumulate=1.
- ALUOwn  out  1  1 = datapath mux routes SeqA/SeqB/SeqCtrl to the ALU.
- SeqA  out  WIDTH  ALU operand A.
- SeqB  out  WIDTH  ALU operand B.
- SeqCtrl  out  3  ALU control code.
- ALUResult  in  WIDTH  combinational ALU result, returned the same cycle.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; Product and Flags are valid.
- Product  out  WIDTH  result, held until the next accepted Start.
- Flags  out  2  {N, Z} of Product, held with Product.

## Operation
- FSM states: IDLE, STEP, DONE.
- IDLE/DONE with Start=1, on the clock edge:
  - P <= Accumulate ? Addend : 0; Mreg <= Multiplicand; Qreg <= Multiplier; cnt <= 0.
  - Go to STEP.
- STEP, each cycle:
  - ALUOwn=1, SeqA=P, SeqB = Qreg[0] ? Mreg : 0, SeqCtrl=3'b000 (add).
  - On the edge: P <= ALUResult; Mreg <= Mreg<<1; Qreg <= Qreg>>1; cnt <= cnt+1.
- Exit from STEP to DONE when cnt==WIDTH-1. Otherwise stay in STEP.
- DONE (one cycle):
  - Done=1; Product=P; Flags = {P[31], P==0}.
  - Without Start, go to IDLE.
  - With Start, accept the new operation and go to STEP; Done is still 1 in that cycle.
- Outside STEP: ALUOwn=0, SeqA=0, SeqB=0, SeqCtrl=3'b000.
- Arithmetic:
  - Results are modulo 2^WIDTH; overflow is discarded silently.
  - Operands are unsigned; the low word is identical for signed operands.
  - The ALU carry and overflow flags are ignored.
- Start in STEP is ignored; the operation in flight is unaffected.
- Operand inputs are don't-care except in the Start acceptance cycle.

## Timing
- Reset (any state, including mid-STEP):
  - FSM returns to IDLE; no Done is issued for the aborted operation.
  - Busy=0, Done=0, ALUOwn=0, SeqA=SeqB=0, SeqCtrl=0, Product=0, Flags=2'b01, P/Mreg/Qreg/cnt=0.
- Start accepted at edge 0:
  - STEP occupies cycles 1..n; n=WIDTH without the macro.
  - DONE occurs in cycle n+1; Done is registered and visible in cycle n+1.
- Busy=1 exactly during STEP cycles; ALUOwn equals Busy.
- Back-to-back: Start during DONE gives a new STEP beginning the following cycle, with zero idle cycles.
- One ALU add per cycle; there is no combinational path from Start to Seq* outputs.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - STEP also exits to DONE when Qreg[WIDTH-1:1]==0 in the current cycle, i.e. no further set multiplier bits remain.
  - n = max(1, index of highest set bit of Multiplier + 1); Multiplier=0 gives n=1.
- Undefined: fixed n=WIDTH for every operation. The results are identical either way.

## Structure
- Package mul_seq_pkg holds:
  - the state enum {IDLE, STEP, DONE};
  - ALU control constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_ORR=3'b011, ALU_EOR=3'b100, ALU_MOV=3'b111;
  - the counter width localparam $clog2(WIDTH).
- No sub-module: the FSM, registers and counter sit inline in mul_seq. The operand mux lives in the datapath, driven by ALUOwn.

## Test plan
- Bench wires a behavioural ALU model behind the ALUOwn mux.
- MUL 7×6, Accumulate=0 → Product=42, Flags=2'b00; Done in cycle 33 with the macro off, Busy high in cycles 1..32.
- MUL 0xFFFFFFFF×2 → Product=0xFFFFFFFE, Flags=2'b10.
- MLA 3×5 + Addend 10 → Product=25; then MUL 0x00010000×0x00010000 → Product=0, Flags=2'b01 (wrap-around).
- Reset asserted in cycle 10 of a run → next cycle Busy=0, ALUOwn=0, no Done; a following MUL 2×2 → Product=4.
- Start pulsed at cycle 5 of a run → ignored, first result correct. Start held during DONE → second operation starts with no gap, second result correct.
- Macro on: Multiplier=1 → Done in cycle 2; Multiplier=0 → Done in cycle 2, Product=Addend with Accumulate=1; Multiplier=0x80000000 → Done in cycle 33.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// ALU control codes mirror the datapath ALU decode.
package mul_seq_pkg;

  localparam int SEQ_WIDTH = 32;
  localparam int CNT_W     = $clog2(SEQ_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b111;

endpackage

// File: rtl/mul_seq.sv
// MUL/MLA sequencer: one shared-ALU add per cycle, low-word product plus {N,Z}.
// Optional MUL_EARLY_EXIT_EN ends the run once no multiplier bits remain.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Accumulate,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  input  logic [WIDTH-1:0] Addend,
  output logic             ALUOwn,
  output logic [WIDTH-1:0] SeqA,
  output logic [WIDTH-1:0] SeqB,
  output logic [2:0]       SeqCtrl,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Product,
  output logic [1:0]       Flags
);

  state_t             state;
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   qreg;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;

  always_comb begin
    last_step = (cnt == CNT_W'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: later adds would only add 0.
    last_step = last_step | (qreg[WIDTH-1:1] == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      p       <= '0;
      mreg    <= '0;
      qreg    <= '0;
      cnt     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
      Flags   <= 2'b01;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            p     <= Accumulate ? Addend : '0;
            mreg  <= Multiplicand;
            qreg  <= Multiplier;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= STEP;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        STEP: begin
          p    <= ALUResult;
          mreg <= mreg << 1;
          qreg <= qreg >> 1;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            Product <= ALUResult;
            Flags   <= {ALUResult[WIDTH-1], (ALUResult == '0)};
            state   <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Operands derive only from registered state, never from Start.
  always_comb begin
    ALUOwn  = Busy;
    SeqA    = Busy ? p : '0;
    SeqB    = (Busy && qreg[0]) ? mreg : '0;
    SeqCtrl = ALU_ADD;
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: behavioural ALU behind the ownership mux, timeline model, random ops.
module tb_mul_seq;
  import mul_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Start = 1'b0;
  logic         Accumulate = 1'b0;
  logic [W-1:0] Multiplicand = '0;
  logic [W-1:0] Multiplier = '0;
  logic [W-1:0] Addend = '0;
  logic         ALUOwn;
  logic [W-1:0] SeqA, SeqB;
  logic [2:0]   SeqCtrl;
  logic [W-1:0] ALUResult;
  logic         Busy, Done;
  logic [W-1:0] Product;
  logic [1:0]   Flags;

  logic [W-1:0] dp_a = '0, dp_b = '0;
  logic [2:0]   dp_ctrl = '0;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_ctrl;

  int checks = 0;
  int failures = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Accumulate(Accumulate),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier), .Addend(Addend),
    .ALUOwn(ALUOwn), .SeqA(SeqA), .SeqB(SeqB), .SeqCtrl(SeqCtrl),
    .ALUResult(ALUResult), .Busy(Busy), .Done(Done),
    .Product(Product), .Flags(Flags)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_ORR: return a | b;
      ALU_EOR: return a ^ b;
      ALU_MOV: return b;
      default: return '0;
    endcase
  endfunction

  // The rest of the datapath drives the ALU with unrelated traffic when it owns it.
  assign alu_a     = ALUOwn ? SeqA : dp_a;
  assign alu_b     = ALUOwn ? SeqB : dp_b;
  assign alu_ctrl  = ALUOwn ? SeqCtrl : dp_ctrl;
  assign ALUResult = alu_f(alu_a, alu_b, alu_ctrl);

  always @(negedge clk) begin
    dp_a    = $urandom;
    dp_b    = $urandom;
    dp_ctrl = 3'($urandom);
  end

  // Number of STEP cycles an operation occupies.
  function automatic int exp_n(input logic [W-1:0] q);
    int n;
`ifdef MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (q[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  function automatic logic [W-1:0] ref_result(input logic acc, input logic [W-1:0] m,
                                              input logic [W-1:0] q, input logic [W-1:0] a);
    logic [W-1:0] r;
    r = m * q;
    if (acc) r = r + a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: remaining STEP cycles, pending result, visible result.
  int           rem = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_pend = '0, m_prod = '0;
  logic [1:0]   m_flags = 2'b01;
  bit           cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      rem = 0; m_done = 1'b0; m_prod = '0; m_flags = 2'b01; cmp_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done  = 1'b1;
          m_prod  = m_pend;
          m_flags = {m_pend[W-1], (m_pend == '0)};
        end
      end else if (Start) begin
        rem    = exp_n(Multiplier);
        m_pend = ref_result(Accumulate, Multiplicand, Multiplier, Addend);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(Busy), 32'(rem > 0));
      check("alu_own", 32'(ALUOwn), 32'(rem > 0));
      check("done", 32'(Done), 32'(m_done));
      if (rem == 0) begin
        check("product", Product, m_prod);
        check("flags", 32'(Flags), 32'(m_flags));
        check("seq_a_idle", SeqA, 32'd0);
        check("seq_b_idle", SeqB, 32'd0);
        check("seq_ctrl_idle", 32'(SeqCtrl), 32'd0);
      end
    end
  end

  // Called at a negedge; Start is sampled at the next posedge (edge 0).
  task automatic do_op(input logic acc, input logic [W-1:0] m, input logic [W-1:0] q,
                       input logic [W-1:0] a, input int pulse_at,
                       output logic [W-1:0] prod, output logic [1:0] fl, output int lat);
    Start = 1'b1; Accumulate = acc; Multiplicand = m; Multiplier = q; Addend = a;
    @(negedge clk);
    Start = 1'b0; Accumulate = 1'($urandom);
    Multiplicand = $urandom; Multiplier = $urandom; Addend = $urandom;
    lat = 1;
    while (!Done && lat < 200) begin
      if (lat == pulse_at) Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      lat++;
    end
    check("done_within_budget", 32'(Done), 32'd1);
    prod = Product;
    fl   = Flags;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [W-1:0] rp, m, q, a;
  logic [1:0]   rf;
  logic         acc;
  int           lat, n, pulse;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_product", Product, 32'd0);
    check("reset_flags", 32'(Flags), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'd7, 32'd6, 32'd0, 0, rp, rf, lat);
    check("mul_7x6", rp, 32'd42);
    check("mul_7x6_flags", 32'(rf), 32'd0);
`ifdef MUL_EARLY_EXIT_EN
    check("mul_7x6_latency", 32'(lat), 32'd4);
`else
    check("mul_7x6_latency", 32'(lat), 32'd33);
`endif

    @(negedge clk);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, rp, rf, lat);
    check("mul_neg", rp, 32'hFFFF_FFFE);
    check("mul_neg_flags", 32'(rf), 32'd2);

    @(negedge clk);
    do_op(1'b1, 32'd3, 32'd5, 32'd10, 0, rp, rf, lat);
    check("mla_3x5p10", rp, 32'd25);
    @(negedge clk);
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 0, rp, rf, lat);
    check("mul_wrap", rp, 32'd0);
    check("mul_wrap_flags", 32'(rf), 32'd1);

    // Abort a long run with reset in its tenth cycle.
    @(negedge clk);
    Start = 1'b1; Accumulate = 1'b0; Multiplicand = 32'd9; Multiplier = 32'h8000_0001;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_alu_own", 32'(ALUOwn), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(Done), 32'd0);
    end
    do_op(1'b0, 32'd2, 32'd2, 32'd0, 0, rp, rf, lat);
    check("mul_2x2_after_abort", rp, 32'd4);

    @(negedge clk);
    do_op(1'b0, 32'd123, 32'd456, 32'd0, 5, rp, rf, lat);
    check("start_pulse_ignored", rp, 32'd56088);
    check("start_pulse_latency", 32'(lat), 32'(exp_n(32'd456) + 1));

    // Back-to-back: second Start presented in the DONE cycle.
    @(negedge clk);
    do_op(1'b1, 32'h1234, 32'h5678, 32'd7, 0, rp, rf, lat);
    check("b2b_first", rp, 32'd103153767);
    do_op(1'b0, 32'd1000, 32'd1000, 32'd0, 0, rp, rf, lat);
    check("b2b_second", rp, 32'd1000000);
    check("b2b_second_latency", 32'(lat), 32'(exp_n(32'd1000) + 1));

`ifdef MUL_EARLY_EXIT_EN
    @(negedge clk);
    do_op(1'b0, 32'd77, 32'd1, 32'd0, 0, rp, rf, lat);
    check("early_q1_latency", 32'(lat), 32'd2);
    check("early_q1", rp, 32'd77);
    @(negedge clk);
    do_op(1'b1, 32'd77, 32'd0, 32'hABCD, 0, rp, rf, lat);
    check("early_q0_latency", 32'(lat), 32'd2);
    check("early_q0", rp, 32'hABCD);
    @(negedge clk);
    do_op(1'b0, 32'd1, 32'h8000_0000, 32'd0, 0, rp, rf, lat);
    check("early_qmsb_latency", 32'(lat), 32'd33);
    check("early_qmsb", rp, 32'h8000_0000);
`endif

    for (int k = 0; k < 30; k++) begin
      acc = 1'($urandom);
      m   = $urandom;
      q   = $urandom >> $urandom_range(0, 31);
      a   = $urandom;
      n   = exp_n(q);
      pulse = (n > 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, n - 1)) : 0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(acc, m, q, a, pulse, rp, rf, lat);
      check("rand_product", rp, ref_result(acc, m, q, a));
      check("rand_latency", 32'(lat), 32'(n + 1));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
